// File: rtl/fifo_rd_stream.sv
// Read-side drain stage for sync_fifo: turns the 1-cycle-latency FIFO read port into a
// bubble-free valid/ready stream. Optional beat counter enabled by FIFO_RD_STREAM_CNT_EN.
module fifo_rd_stream #(
   parameter int unsigned DATAWIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 fifo_empty,
   input  logic [DATAWIDTH-1:0] fifo_dout,
   output logic                 fifo_rd_en,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [DATAWIDTH-1:0] m_data
`ifdef FIFO_RD_STREAM_CNT_EN
   ,
   output logic [15:0]          beat_count
`endif
);

   typedef enum logic [1:0] {StEmpty = 2'd0, StOne = 2'd1, StTwo = 2'd2} occ_e;

   occ_e                 occ_q;
   logic                 pending_q;
   logic [DATAWIDTH-1:0] tail_q;
   logic [1:0]           occ_cnt;
   logic [2:0]           fill;
   logic                 pop;
   logic                 push;

   assign occ_cnt = occ_q;
   assign pop     = m_valid && m_ready;
   assign push    = pending_q;

   // Credit check counts the in-flight read so the 2-entry buffer can never overflow.
   assign fill       = {1'b0, occ_cnt} + {2'b00, pending_q} - {2'b00, pop};
   assign fifo_rd_en = reset && !fifo_empty && (fill < 3'd2);

   // m_data is the head entry; tail_q holds the second word while the sink stalls.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         occ_q     <= StEmpty;
         pending_q <= 1'b0;
         m_valid   <= 1'b0;
         m_data    <= '0;
         tail_q    <= '0;
      end else begin
         pending_q <= fifo_rd_en;
         unique case (occ_q)
            StEmpty: begin
               if (push) begin
                  occ_q   <= StOne;
                  m_valid <= 1'b1;
                  m_data  <= fifo_dout;
               end
            end
            StOne: begin
               if (push && !pop) begin
                  occ_q  <= StTwo;
                  tail_q <= fifo_dout;
               end else if (push && pop) begin
                  m_data <= fifo_dout;
               end else if (pop) begin
                  occ_q   <= StEmpty;
                  m_valid <= 1'b0;
               end
            end
            StTwo: begin
               if (pop) begin
                  m_data <= tail_q;
                  if (push) begin
                     tail_q <= fifo_dout;
                  end else begin
                     occ_q <= StOne;
                  end
               end
            end
            default: begin
               occ_q   <= StEmpty;
               m_valid <= 1'b0;
            end
         endcase
      end
   end

   no_push_when_full: assert property (@(posedge clk) disable iff (!reset)
      !(pending_q && (occ_q == StTwo) && !pop));

`ifdef FIFO_RD_STREAM_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         beat_count <= 16'h0000;
      end else if (pop) begin
         beat_count <= beat_count + 16'h0001;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: a behavioural sync_fifo feeds the DUT, loaded words
// are queued as expected beats and a monitor retires them as the sink accepts.
module tb_fifo_rd_stream;
   localparam int unsigned DW = 8;

   logic          clk        = 1'b0;
   logic          reset      = 1'b0;
   logic          fifo_empty = 1'b1;
   logic [DW-1:0] fifo_dout  = '0;
   logic          fifo_rd_en;
   logic          m_valid;
   logic          m_ready    = 1'b0;
   logic [DW-1:0] m_data;
`ifdef FIFO_RD_STREAM_CNT_EN
   logic [15:0]   beat_count;
`endif

   int            checks   = 0;
   int            failures = 0;
   logic [DW-1:0] mem[$];
   logic [DW-1:0] load_q[$];
   logic [DW-1:0] exp_q[$];
   bit            fifo_flush = 1'b0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data  = '0;

   fifo_rd_stream #(.DATAWIDTH(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .fifo_empty(fifo_empty),
      .fifo_dout (fifo_dout),
      .fifo_rd_en(fifo_rd_en),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data)
`ifdef FIFO_RD_STREAM_CNT_EN
      ,
      .beat_count(beat_count)
`endif
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endfunction

   // Behavioural sync_fifo: registered dout, empty flag updated on the clock edge.
   always @(posedge clk) begin
      if (fifo_flush) begin
         mem.delete();
         load_q.delete();
         fifo_empty <= 1'b1;
      end else begin
         if (fifo_rd_en && mem.size() != 0) fifo_dout <= mem.pop_front();
         while (load_q.size() != 0) mem.push_back(load_q.pop_front());
         fifo_empty <= (mem.size() == 0);
      end
   end

   // Monitor: retires beats against the scoreboard and checks stream hold rules.
   always @(negedge clk or negedge reset) begin
      if (!reset) begin
         prev_stall = 1'b0;
      end else begin
         #2;
         if (reset) begin
            if (fifo_rd_en) check("rd_en_while_empty", 32'(fifo_empty), 32'd0);
            if (prev_stall) begin
               check("hold_valid", 32'(m_valid), 32'd1);
               check("hold_data", 32'(m_data), 32'(prev_data));
            end
            if (m_valid && m_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL extra_beat: got 0x%0h expected no beat", m_data);
               end else begin
                  check("beat_data", 32'(m_data), 32'(exp_q.pop_front()));
               end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
         end
      end
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic load(input logic [DW-1:0] w);
      load_q.push_back(w);
      exp_q.push_back(w);
   endtask

   task automatic drain(input string name, input int bound);
      int n = 0;
      while ((exp_q.size() != 0 || m_valid) && n < bound) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int pulses;
      int n;

      // Reset held with a non-empty FIFO: nothing may be issued or presented.
      load(8'h11);
      load(8'h22);
      repeat (4) begin
         @(negedge clk);
         #1;
         check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
         check("rst_valid", 32'(m_valid), 32'd0);
         check("rst_data", 32'(m_data), 32'd0);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("release_rd_en", 32'(fifo_rd_en), 32'd1);
      m_ready = 1'b1;
      drain("drain_t1", 20);

      // Single word: rd_en one cycle, beat two cycles later for one cycle.
      @(negedge clk);
      load(8'hA5);
      @(negedge clk); #1;
      check("t2_rd_en_n", 32'(fifo_rd_en), 32'd1);
      check("t2_valid_n", 32'(m_valid), 32'd0);
      @(negedge clk); #1;
      check("t2_rd_en_n1", 32'(fifo_rd_en), 32'd0);
      check("t2_valid_n1", 32'(m_valid), 32'd0);
      @(negedge clk); #1;
      check("t2_valid_n2", 32'(m_valid), 32'd1);
      check("t2_data_n2", 32'(m_data), 32'hA5);
      @(negedge clk); #1;
      check("t2_valid_n3", 32'(m_valid), 32'd0);

      // Eight words, sink always ready: back-to-back beats.
      @(negedge clk);
      for (int i = 0; i < 8; i++) load(8'(i));
      repeat (3) @(negedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         check("t3_valid", 32'(m_valid), 32'd1);
         check("t3_data", 32'(m_data), 32'(i));
         @(negedge clk); #1;
      end
      check("t3_valid_end", 32'(m_valid), 32'd0);

      // Backpressure: only two reads may be issued while stalled.
      @(negedge clk);
      m_ready = 1'b0;
      for (int i = 0; i < 8; i++) load(8'(i));
      pulses = 0;
      repeat (10) begin
         @(negedge clk); #1;
         if (fifo_rd_en) pulses++;
      end
      check("t4_rd_pulses", 32'(pulses), 32'd2);
      check("t4_occ", 32'(dut.occ_q), 32'd2);
      check("t4_valid", 32'(m_valid), 32'd1);
      check("t4_data", 32'(m_data), 32'h00);
      @(negedge clk);
      m_ready = 1'b1;
      drain("drain_t4", 40);

      // Alternating ready.
      @(negedge clk);
      for (int i = 0; i < 8; i++) load(8'(8'h30 + i));
      n = 0;
      while ((exp_q.size() != 0 || m_valid) && n < 60) begin
         @(negedge clk);
         m_ready = ~m_ready;
         n++;
      end
      check("drain_t5", 32'(exp_q.size()), 32'd0);
      m_ready = 1'b1;

      // Reset mid-stream with a read in flight.
      @(negedge clk);
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) load(8'(8'h40 + i));
      repeat (3) @(negedge clk);
      #1;
      check("t6_pending", 32'(dut.pending_q), 32'd1);
      check("t6_valid_pre", 32'(m_valid), 32'd1);
      #2;
      reset      = 1'b0;
      fifo_flush = 1'b1;
      exp_q.delete();
      #1;
      check("t6_async_valid", 32'(m_valid), 32'd0);
      check("t6_async_data", 32'(m_data), 32'd0);
      check("t6_async_rd_en", 32'(fifo_rd_en), 32'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
      check("t6_count_rst", 32'(beat_count), 32'd0);
`endif
      @(negedge clk);
      fifo_flush = 1'b0;
      reset      = 1'b1;
      m_ready    = 1'b1;
      repeat (3) begin
         @(negedge clk); #1;
         check("t6_no_stale", 32'(m_valid), 32'd0);
      end

      // Recovery after reset.
      @(negedge clk);
      load(8'h55);
      drain("drain_t6", 20);

`ifdef FIFO_RD_STREAM_CNT_EN
      check("cnt_one", 32'(beat_count), 32'd1);
      @(negedge clk);
      for (int i = 0; i < 65534; i++) load(8'(i));
      drain("drain_cnt", 70000);
      check("cnt_ffff", 32'(beat_count), 32'hFFFF);
      @(negedge clk);
      load(8'hEE);
      drain("drain_wrap", 20);
      check("cnt_wrap", 32'(beat_count), 32'h0000);
`endif

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
